// File: rtl/midi_rx_decoder.sv
// MIDI serial receiver (8N1) with a channel voice message parser that emits
// one-cycle note event strobes. Handles running status, real-time bytes and framing errors.
module midi_rx_decoder #(
    parameter int CLKS_PER_BIT = 1024
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       midi_in,
    output logic       note_pressed,
    output logic       note_released,
    output logic       note_keypress,
    output logic       note_channelpress,
    output logic [6:0] note_interface,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic       framing_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift, shift_next;
    logic             rx_valid, rx_valid_next;
    logic             fe_next;
    logic             sync0, sync1, sync_prev;

    logic [7:0] running_status;
    logic [1:0] data_cnt;
    logic [6:0] data0;
    logic       one_byte_msg;

    // Synchronizer flops reset high so an idle line never looks like a start edge
    always_ff @(posedge clk32) begin
        if (rst) begin
            sync0     <= 1'b1;
            sync1     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync0     <= midi_in;
            sync1     <= sync0;
            sync_prev <= sync1;
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bit_cnt       <= bit_cnt_next;
            shift         <= shift_next;
            rx_valid      <= rx_valid_next;
            framing_error <= fe_next;
        end
    end

    // The bit timer restarts at every sample, so each sample is one full bit after the last
    always_comb begin
        state_next    = state;
        cnt_next      = cnt + 1'b1;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        rx_valid_next = 1'b0;
        fe_next       = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (sync_prev && !sync1) begin
                    state_next   = START;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_next   = '0;
                    state_next = sync1 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_next     = '0;
                    shift_next   = {sync1, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_next = '0;
                    if (sync1) begin
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (sync1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign one_byte_msg = (running_status[7:4] == 4'hC) || (running_status[7:4] == 4'hD);

    // Message parser: the received byte stays in shift while rx_valid is high
    always_ff @(posedge clk32) begin
        if (rst) begin
            running_status    <= 8'h00;
            data_cnt          <= 2'd0;
            data0             <= 7'd0;
            note_pressed      <= 1'b0;
            note_released     <= 1'b0;
            note_keypress     <= 1'b0;
            note_channelpress <= 1'b0;
            note_interface    <= 7'd0;
            velocity          <= 7'd0;
            channel           <= 4'd0;
        end else begin
            note_pressed      <= 1'b0;
            note_released     <= 1'b0;
            note_keypress     <= 1'b0;
            note_channelpress <= 1'b0;
            if (framing_error) begin
                data_cnt <= 2'd0;
            end else if (rx_valid) begin
                if (shift[7]) begin
                    if (shift < 8'hF0) begin
                        running_status <= shift;
                        data_cnt       <= 2'd0;
                    end else if (shift < 8'hF8) begin
                        running_status <= 8'h00;
                        data_cnt       <= 2'd0;
                    end
                end else if (running_status != 8'h00) begin
                    if (!one_byte_msg && data_cnt == 2'd0) begin
                        data0    <= shift[6:0];
                        data_cnt <= 2'd1;
                    end else begin
                        data_cnt <= 2'd0;
                        case (running_status[7:4])
                            4'h8, 4'h9, 4'hA: begin
                                note_pressed   <= (running_status[7:4] == 4'h9) && (shift[6:0] != 7'd0);
                                note_released  <= (running_status[7:4] == 4'h8) ||
                                                  ((running_status[7:4] == 4'h9) && (shift[6:0] == 7'd0));
                                note_keypress  <= (running_status[7:4] == 4'hA);
                                note_interface <= data0;
                                velocity       <= shift[6:0];
                                channel        <= running_status[3:0];
                            end
                            4'hD: begin
                                note_channelpress <= 1'b1;
                                velocity          <= shift[6:0];
                                channel           <= running_status[3:0];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_rx_decoder.sv
// Scoreboard bench for midi_rx_decoder: a queue-based message model predicts every
// event strobe, and a monitor checks each strobe against the next prediction.
`timescale 1ns/1ps
module tb_midi_rx_decoder;

    localparam int CPB = 32;
    localparam int K_PRS = 0, K_REL = 1, K_KEY = 2, K_CHP = 3, K_FE = 4;

    typedef struct {
        int         kind;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] ch;
    } ev_t;

    logic       clk32 = 1'b0;
    logic       rst;
    logic       midi_in;
    logic       note_pressed, note_released, note_keypress, note_channelpress;
    logic [6:0] note_interface, velocity;
    logic [3:0] channel;
    logic       framing_error;

    int compared = 0;
    int mismatched = 0;

    ev_t        exp_q[$];
    logic [6:0] pend[$];
    int         rs;
    logic [6:0] m_note, m_vel;
    logic [3:0] m_ch;

    midi_rx_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk32             (clk32),
        .rst               (rst),
        .midi_in           (midi_in),
        .note_pressed      (note_pressed),
        .note_released     (note_released),
        .note_keypress     (note_keypress),
        .note_channelpress (note_channelpress),
        .note_interface    (note_interface),
        .velocity          (velocity),
        .channel           (channel),
        .framing_error     (framing_error)
    );

    always #15 clk32 = ~clk32;

    task automatic push_event(input int kind, input logic [6:0] n, input logic [6:0] v,
                              input logic [3:0] c);
        ev_t e;
        e.kind = kind;
        e.note = n;
        e.vel  = v;
        e.ch   = c;
        if (kind != K_FE) begin
            m_note = n;
            m_vel  = v;
            m_ch   = c;
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        rs = -1;
        pend.delete();
        m_note = '0;
        m_vel  = '0;
        m_ch   = '0;
    endtask

    // Messages are collected as a list of pending data bytes until the status's length is reached
    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        int need;
        logic [6:0] last;
        logic [3:0] ch;
        if (!stop_ok) begin
            pend.delete();
            push_event(K_FE, m_note, m_vel, m_ch);
            return;
        end
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            rs = -1;
            pend.delete();
            return;
        end
        if (b >= 8'h80) begin
            rs = int'(b);
            pend.delete();
            return;
        end
        if (rs < 0) return;
        pend.push_back(b[6:0]);
        need = ((rs >> 4) == 'hC || (rs >> 4) == 'hD) ? 1 : 2;
        if (pend.size() < need) return;
        last = pend[pend.size() - 1];
        ch   = 4'(rs % 16);
        case (rs >> 4)
            'h8: push_event(K_REL, pend[0], last, ch);
            'h9: push_event((last != 0) ? K_PRS : K_REL, pend[0], last, ch);
            'hA: push_event(K_KEY, pend[0], last, ch);
            'hD: push_event(K_CHP, m_note, last, ch);
            default: ;
        endcase
        pend.delete();
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic stop_ok, input int gap_bits,
                                  input logic to_model);
        if (to_model) model_byte(b, stop_ok);
        @(negedge clk32);
        midi_in = 1'b0;
        repeat (CPB) @(negedge clk32);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            repeat (CPB) @(negedge clk32);
        end
        midi_in = stop_ok;
        repeat (CPB) @(negedge clk32);
        midi_in = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk32);
        repeat (gap_bits * CPB) @(negedge clk32);
    endtask

    task automatic send(input logic [7:0] b);
        apply_stimulus(b, 1'b1, 1, 1'b1);
    endtask

    task automatic check_output(input string tag);
        compared++;
        if (note_interface !== m_note || velocity !== m_vel || channel !== m_ch) begin
            mismatched++;
            $display("[TB] FAIL hold_%s: got note=%h vel=%h ch=%h, required note=%h vel=%h ch=%h",
                     tag, note_interface, velocity, channel, m_note, m_vel, m_ch);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted event
    initial begin
        logic [4:0] strobes;
        logic [4:0] want;
        ev_t        e;
        forever begin
            @(negedge clk32);
            if (rst !== 1'b0) continue;
            strobes = {framing_error, note_channelpress, note_keypress, note_released, note_pressed};
            if (strobes != 5'b0) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_event: got strobes=%b, required none", strobes);
                end else begin
                    e    = exp_q.pop_front();
                    want = 5'b1 << e.kind;
                    if (strobes != want || note_interface != e.note || velocity != e.vel ||
                        channel != e.ch) begin
                        mismatched++;
                        $display("[TB] FAIL event: got strobes=%b note=%h vel=%h ch=%h, required strobes=%b note=%h vel=%h ch=%h",
                                 strobes, note_interface, velocity, channel, want, e.note, e.vel, e.ch);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        rst     = 1'b1;
        midi_in = 1'b1;
        model_reset();
        repeat (5) @(negedge clk32);
        compared++;
        if ({framing_error, note_channelpress, note_keypress, note_released, note_pressed} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_strobes: got %b, required 00000",
                     {framing_error, note_channelpress, note_keypress, note_released, note_pressed});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk32);
        check_output("reset");

        send(8'h93); send(8'h3C); send(8'h64);
        check_output("note_on");

        send(8'h90); send(8'h40); send(8'h50);
        send(8'h40); send(8'hF8); send(8'h00);
        check_output("running_status");

        send(8'h80); send(8'h30);
        apply_stimulus(8'h7F, 1'b0, 1, 1'b1);
        send(8'h31); send(8'h22);
        check_output("framing");

        send(8'hD5); send(8'h40);
        check_output("chan_press");
        send(8'hC2); send(8'h05);
        check_output("program_change");

        @(negedge clk32);
        midi_in = 1'b0;
        repeat (CPB / 4) @(negedge clk32);
        midi_in = 1'b1;
        repeat (2 * CPB) @(negedge clk32);
        check_output("glitch");
        send(8'hF0); send(8'h12); send(8'h34); send(8'hF7);
        send(8'h45); send(8'h45);
        check_output("sysex");

        send(8'h90);
        fork
            apply_stimulus(8'h90, 1'b1, 0, 1'b0);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk32);
                rst = 1'b1;
                repeat (3) @(negedge clk32);
                rst = 1'b0;
            end
        join
        model_reset();
        repeat (12 * CPB) @(negedge clk32);
        send(8'h3C); send(8'h64);
        check_output("reset_midframe");

        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      b = {4'h8 + 4'($urandom_range(0, 6)), 4'($urandom_range(0, 15))};
            else if (r < 20) b = 8'($urandom_range(248, 255));
            else if (r < 23) b = 8'($urandom_range(240, 247));
            else if (r < 40) b = 8'h00;
            else             b = 8'($urandom_range(0, 127));
            apply_stimulus(b, ($urandom_range(0, 19) != 0), $urandom_range(0, 2), 1'b1);
            if (n % 10 == 9) check_output("random");
        end

        repeat (4 * CPB) @(negedge clk32);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/midi_rx_decoder.md
# midi_rx_decoder

- Receives the raw MIDI serial line (31250 baud, 8N1) and decodes channel voice messages into one-cycle note event strobes.
- Its outputs carry note number, velocity and channel, and drive the note-event inputs of the synth voice engine directly.
- It handles running status, real-time byte interleaving, and Note On with velocity 0 (treated as a release).
- It flags framing errors.

## Interface
- CLKS_PER_BIT, default 1024: clk32 cycles per MIDI bit (32 MHz / 31250).
- clk32  in  1  system clock, 32 MHz.
- rst  in  1  reset; synchronous, active-high. Clock is clk32.
- midi_in  in  1  asynchronous MIDI serial input; idle high.
- note_pressed  out  1  one-cycle strobe: Note On with velocity ≠ 0.
- note_released  out  1  one-cycle strobe: Note Off, or Note On with velocity 0.
- note_keypress  out  1  one-cycle strobe: polyphonic aftertouch (An).
- note_channelpress  out  1  one-cycle strobe: channel pressure (Dn).
- note_interface  out  7  note number of the last event.
- velocity  out  7  velocity or pressure of the last event.
- channel  out  4  MIDI channel of the last event.
- framing_error  out  1  one-cycle strobe when a stop bit is sampled low.

## Operation
- **Input conditioning:** midi_in passes through a 2-flop synchronizer. Both flops reset to 1.
- **UART receiver states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synchronized 1→0 transition goes to START and clears the bit counter.
  - START: sample at CLKS_PER_BIT/2. If the sample is low, go to DATA. If high (a glitch), return to IDLE with no byte.
  - DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles from the start-bit mid-point.
  - STOP: sample one bit period after data bit 7.
    - High: raise an internal rx_valid for one cycle with the byte, then go to IDLE.
    - Low: pulse framing_error, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE when the synchronized line is high.
- **Parser state:** running_status[7:0], whose value 0x00 means "none"; data_cnt[1:0]; data0[6:0].
- **Byte classes:**
  - 0x80–0xEF (channel status): running_status ← byte, data_cnt ← 0.
  - 0xF0–0xF7 (system common / SysEx): running_status ← none, data_cnt ← 0. All subsequent data bytes are ignored until a new channel status arrives.
  - 0xF8–0xFF (real-time): ignored entirely; running_status and data_cnt are unchanged.
  - 0x00–0x7F (data):
    - Ignored if running_status is none.
    - Otherwise, a 1-byte message type (Cn, Dn) completes on this byte.
    - For a 2-byte type (8n, 9n, An, Bn, En): if data_cnt=0, store data0 and set data_cnt=1. If data_cnt=1, the message completes and data_cnt ← 0.
- **Completed message actions:** channel ← running_status[3:0] for every emitted event.
  - 8n: note_released, note_interface=data0, velocity=byte.
  - 9n with byte≠0: note_pressed, note_interface=data0, velocity=byte.
  - 9n with byte=0: note_released, note_interface=data0, velocity=0.
  - An: note_keypress, note_interface=data0, velocity=byte.
  - Dn: note_channelpress, note_interface unchanged, velocity=byte.
  - Bn, Cn, En: consumed, no strobe, outputs unchanged.
- **Output holding:** note_interface, velocity and channel hold their values between events. They change only in the cycle a strobe asserts.
- **Framing errors:** a framing error clears data_cnt but keeps running_status. The next data byte is therefore treated as the first byte of a message.
- **Strobe exclusivity:** at most one of the four event strobes is high in any cycle.

## Timing
- **Reset values:** all strobes 0; note_interface=0, velocity=0, channel=0, framing_error=0; running_status=none, data_cnt=0; receiver in IDLE.
- **Reset mid-frame:** reset during a frame aborts it. No byte and no strobe is produced. The receiver waits for a fresh falling edge after reset is released.
- **Latency:** 2 cycles (synchronizer) plus 0.5 bit to the start sample.
- **Sample spacing:** stop sample = start sample + 9·CLKS_PER_BIT.
- **Internal rx_valid:** asserts the cycle after the stop sample.
- **Event strobe and data outputs:** register the cycle after rx_valid, i.e. stop sample + 2 cycles.
- **Framing error strobe:** framing_error asserts the cycle after the stop sample.
- **Back-to-back frames:** a start edge arriving immediately after the stop sample is accepted with no lost byte. Receiver is back in IDLE at stop sample + 1.
- **Counters:**
  - Bit-timing counter width = clog2(CLKS_PER_BIT)+1.
  - No wrap-around hazard, because it is reloaded at every sample.

## Test plan
- **Note On:** send 0x93 0x3C 0x64 → one note_pressed pulse; note_interface=0x3C, velocity=0x64, channel=3. No other strobe.
- **Running status, zero velocity, and real-time interleave:**
  - Stimulus: 0x90 0x40 0x50, then 0x40 0xF8 0x00.
  - Required: note_pressed (0x40, 0x50) first.
  - Then exactly one note_released (0x40, vel 0, ch 0); the 0xF8 produces nothing.
- **Framing error:**
  - Stimulus: 0x80 0x30, then 0x7F with the stop bit held low for 1 bit, then 0x31 0x22.
  - Required: framing_error pulse on the bad byte.
  - Then a single note_released with note=0x31, velocity=0x22.
- **Channel pressure and program change:**
  - Stimulus: 0xD5 0x40, then 0xC2 0x05.
  - Required: note_channelpress with velocity=0x40, channel=5, note_interface unchanged.
  - Program change produces no strobe and no output change.
- **Start glitch and SysEx:**
  - A 200-cycle low pulse on idle → no byte.
  - 0xF0 0x12 0x34 0xF7 followed by 0x45 0x45 → no strobes.
- **Reset mid-frame:** assert rst during data bit 4 of 0x90, then send 0x3C 0x64 → no strobe, because running status was cleared.
